// File: rtl/ring_buffer_reader.sv
// Pulls words from an upstream ring buffer into a 2-entry holding FIFO and
// presents them as a valid/ready stream framed into FrameLengthWords beats.
module ring_buffer_reader #(
  parameter int WordLengthBits   = 8,
  parameter int FrameLengthWords = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      fifo_get,
  input  logic [WordLengthBits-1:0] fifo_data_out,
  input  logic                      fifo_data_out_valid,
  input  logic                      fifo_buffer_empty,
  output logic [WordLengthBits-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      overflow_error
);
  localparam int BW = (FrameLengthWords > 1) ? $clog2(FrameLengthWords) : 1;
  localparam logic [BW-1:0] LastBeat = BW'(FrameLengthWords - 1);

  logic [WordLengthBits-1:0] mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    occ;
  logic [BW-1:0] beat;
  logic          pop, wr, ovf;
  logic [2:0]    occ_after;

  assign pop       = out_valid && out_ready;
  assign occ_after = {1'b0, occ} + {2'b0, fifo_data_out_valid} - {2'b0, pop};
  // A word arriving into a full store with no pop has nowhere to go.
  assign ovf       = fifo_data_out_valid && (occ == 2'd2) && !pop;
  assign wr        = fifo_data_out_valid && !ovf;

  // Only ask for a word if the store is guaranteed room when it lands.
  assign fifo_get  = rst_n && enable && !fifo_buffer_empty && (occ_after <= 3'd1);

  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign out_last  = out_valid && (beat == LastBeat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ            <= 2'd0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      beat           <= '0;
      overflow_error <= 1'b0;
    end else begin
      occ <= occ + {1'b0, wr} - {1'b0, pop};
      if (wr)  wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        beat   <= (beat == LastBeat) ? '0 : beat + 1'b1;
      end
      if (ovf) overflow_error <= 1'b1;
    end
  end

  // With occ==2 and a pop, wr_ptr equals rd_ptr: the slot being vacated is reused.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= fifo_data_out;
  end

endmodule

// File: tb/tb_ring_buffer_reader.sv
// Randomized bench for ring_buffer_reader: an upstream ring model plus an
// in-order scoreboard with frame position tracked by delivered-word count.
module tb_ring_buffer_reader;
  localparam int W = 8;
  localparam int F = 16;

  logic         clk, rst_n, enable, fifo_get;
  logic [W-1:0] fifo_data_out, out_data;
  logic         fifo_data_out_valid, fifo_buffer_empty;
  logic         out_valid, out_ready, out_last, overflow_error;

  ring_buffer_reader #(.WordLengthBits(W), .FrameLengthWords(F)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_get(fifo_get),
    .fifo_data_out(fifo_data_out), .fifo_data_out_valid(fifo_data_out_valid),
    .fifo_buffer_empty(fifo_buffer_empty), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .overflow_error(overflow_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nerr   = 0;

  logic [W-1:0] ring[$];   // upstream ring buffer contents
  logic [W-1:0] sb[$];     // fetched words not yet delivered, oldest first
  int           occ_m;     // words landed in the DUT, not yet delivered
  int           beat_m;    // delivered words since reset, modulo F
  bit           pend_v;
  logic [W-1:0] pend_d;

  // One clock of the environment: drive, observe, then advance the model.
  task automatic step(input bit rdy, input bit en,
                      output bit get, output bit eget, output bit val, output bit mv,
                      output logic [W-1:0] d, output logic [W-1:0] ed,
                      output bit last, output bit el);
    bit mpop;
    @(negedge clk);
    out_ready           = rdy;
    enable              = en;
    fifo_buffer_empty   = (ring.size() == 0);
    fifo_data_out_valid = pend_v;
    fifo_data_out       = pend_v ? pend_d : W'($urandom);
    #1;
    mv   = (occ_m != 0);
    mpop = mv && rdy;
    get  = fifo_get;
    val  = out_valid;
    d    = out_data;
    last = out_last;
    eget = en && (ring.size() != 0) && ((occ_m + int'(pend_v) - int'(mpop)) <= 1);
    ed   = (sb.size() != 0) ? sb[0] : '0;
    el   = (beat_m == F - 1);
    @(posedge clk);
    if (mpop) begin
      void'(sb.pop_front());
      beat_m = (beat_m + 1) % F;
      occ_m--;
    end
    if (pend_v) occ_m++;
    pend_v = 1'b0;
    if (get && ring.size() != 0) begin
      pend_d = ring.pop_front();
      sb.push_back(pend_d);
      pend_v = 1'b1;
    end
  endtask

  task automatic clear_model();
    sb.delete();
    occ_m  = 0;
    beat_m = 0;
    pend_v = 1'b0;
    fifo_data_out_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ring.delete();
    clear_model();
    fifo_buffer_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b1; out_ready = 1'b1; fifo_buffer_empty = 1'b0;
    fifo_data_out_valid = 1'b0;
    #1;
    ntests++;
    if ({fifo_get, out_valid, out_last, overflow_error} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_outputs: get/valid/last/ovf=%b want 0000",
               {fifo_get, out_valid, out_last, overflow_error});
    end
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    bit get, eget, val, mv, last, el;
    logic [W-1:0] d, ed;
    int npop = 0;
    do_reset();
    for (int k = 1; k <= 32; k++) ring.push_back(W'(k));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, get, eget, val, mv, d, ed, last, el);
      ntests++;
      if ({get, val} !== {eget, mv}) begin
        nerr++; $display("FAIL stream_ctl: get,valid=%b%b want %b%b", get, val, eget, mv);
      end
      if (val) begin
        ntests++;
        if (i != 2 + npop || d !== W'(npop + 1) || last !== (npop % F == F - 1)) begin
          nerr++;
          $display("FAIL stream_word: cycle %0d data %h last %b want cycle %0d data %h last %b",
                   i, d, last, 2 + npop, W'(npop + 1), (npop % F == F - 1));
        end
        npop++;
      end
    end
    ntests++;
    if (npop != 32) begin nerr++; $display("FAIL stream_count: %0d words want 32", npop); end
  endtask

  task automatic test_backpressure();
    bit get, eget, val, mv, last, el, rdy;
    bit prev_stall = 1'b0;
    logic [W-1:0] d, ed, prev_d = '0;
    int npop = 0;
    do_reset();
    for (int k = 0; k < 40; k++) ring.push_back(W'($urandom));
    for (int i = 0; i < 300 && npop < 40; i++) begin
      rdy = (i % 4 == 0) || (i % 4 == 3);
      step(rdy, 1'b1, get, eget, val, mv, d, ed, last, el);
      ntests++;
      if ({get, val} !== {eget, mv}) begin
        nerr++; $display("FAIL bp_ctl: get,valid=%b%b want %b%b", get, val, eget, mv);
      end
      if (prev_stall) begin
        ntests++;
        if (!val || d !== prev_d) begin
          nerr++; $display("FAIL bp_stable: valid %b data %h want 1 %h", val, d, prev_d);
        end
      end
      if (val && rdy) begin
        ntests++;
        if ({d, last} !== {ed, el}) begin
          nerr++; $display("FAIL bp_word: data %h last %b want %h %b", d, last, ed, el);
        end
        npop++;
      end
      prev_stall = val && !rdy;
      prev_d     = d;
    end
    ntests++;
    if (npop != 40 || overflow_error !== 1'b0) begin
      nerr++; $display("FAIL bp_total: %0d words ovf %b want 40 0", npop, overflow_error);
    end
  endtask

  task automatic test_empty();
    bit get, eget, val, mv, last, el;
    logic [W-1:0] d, ed;
    int ngets = 0, npop = 0;
    do_reset();
    for (int k = 0; k < 3; k++) ring.push_back(W'(8'h30 + k));
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, get, eget, val, mv, d, ed, last, el);
      ntests++;
      if (get && fifo_buffer_empty) begin
        nerr++; $display("FAIL empty_get: get=1 while empty, want 0");
      end
      if (val) begin
        ntests++;
        if (d !== ed) begin nerr++; $display("FAIL empty_word: data %h want %h", d, ed); end
        npop++;
      end
      if (get) ngets++;
    end
    ntests++;
    if (ngets != 3 || npop != 3) begin
      nerr++; $display("FAIL empty_count: gets %0d words %0d want 3 3", ngets, npop);
    end
  endtask

  task automatic test_enable_drop();
    bit get, eget, val, mv, last, el;
    logic [W-1:0] d, ed;
    int ngets = 0, npop = 0;
    do_reset();
    for (int k = 0; k < 6; k++) ring.push_back(W'(8'h50 + k));
    step(1'b1, 1'b1, get, eget, val, mv, d, ed, last, el);
    ntests++;
    if (get !== 1'b1) begin nerr++; $display("FAIL en_first_get: get %b want 1", get); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, get, eget, val, mv, d, ed, last, el);
      if (get) ngets++;
      if (val) begin
        npop++;
        ntests++;
        if (d !== 8'h50) begin nerr++; $display("FAIL en_inflight: data %h want 50", d); end
      end
    end
    ntests++;
    if (ngets != 0 || npop != 1) begin
      nerr++; $display("FAIL en_drop: gets %0d words %0d want 0 1", ngets, npop);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, get, eget, val, mv, d, ed, last, el);
      if (val) begin
        npop++;
        ntests++;
        if (d !== W'(8'h50 + npop - 1) || last !== el) begin
          nerr++; $display("FAIL en_resume: data %h last %b want %h %b",
                           d, last, W'(8'h50 + npop - 1), el);
        end
      end
    end
    ntests++;
    if (npop != 6) begin nerr++; $display("FAIL en_total: %0d words want 6", npop); end
  endtask

  task automatic test_reset_mid_frame();
    bit get, eget, val, mv, last, el;
    logic [W-1:0] d, ed;
    int npop = 0;
    do_reset();
    for (int k = 0; k < 60; k++) ring.push_back(W'(k + 8'h80));
    for (int i = 0; i < 20 && npop < 5; i++) begin
      step(1'b1, 1'b1, get, eget, val, mv, d, ed, last, el);
      if (val) npop++;
    end
    #3 rst_n = 1'b0;
    #1;
    ntests++;
    if ({out_valid, fifo_get, out_last} !== 3'b000) begin
      nerr++; $display("FAIL mid_reset_async: valid/get/last=%b want 000",
                       {out_valid, fifo_get, out_last});
    end
    clear_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
    npop = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 1'b1, get, eget, val, mv, d, ed, last, el);
      if (val) begin
        ntests++;
        if (last !== (npop == F - 1) || d !== ed) begin
          nerr++; $display("FAIL mid_reset_frame: word %0d data %h last %b want %h %b",
                           npop, d, last, ed, (npop == F - 1));
        end
        npop++;
      end
    end
  endtask

  task automatic test_overflow();
    bit get, eget, val, mv, last, el;
    logic [W-1:0] d, ed, d0;
    int npop = 0;
    do_reset();
    for (int k = 0; k < 5; k++) ring.push_back(W'(8'hA0 + k));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, get, eget, val, mv, d, ed, last, el);
    d0 = out_data;
    @(negedge clk);
    out_ready = 1'b0; enable = 1'b0;
    fifo_data_out_valid = 1'b1; fifo_data_out = 8'hEE;
    @(posedge clk);
    #1;
    ntests++;
    if ({overflow_error, out_valid} !== 2'b11 || out_data !== d0 || d0 !== 8'hA0) begin
      nerr++; $display("FAIL ovf_set: ovf %b valid %b data %h want 1 1 a0",
                       overflow_error, out_valid, out_data);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, get, eget, val, mv, d, ed, last, el);
      if (val) begin
        ntests++;
        if (d !== W'(8'hA0 + npop)) begin
          nerr++; $display("FAIL ovf_held: data %h want %h", d, W'(8'hA0 + npop));
        end
        npop++;
      end
    end
    ntests++;
    if (npop != 2 || overflow_error !== 1'b1) begin
      nerr++; $display("FAIL ovf_sticky: words %0d ovf %b want 2 1", npop, overflow_error);
    end
    do_reset();
    #1;
    ntests++;
    if (overflow_error !== 1'b0) begin nerr++; $display("FAIL ovf_clear: %b want 0", overflow_error); end
  endtask

  task automatic test_random();
    bit get, eget, val, mv, last, el, rdy, en;
    logic [W-1:0] d, ed;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if (ring.size() < 3 && $urandom_range(0, 2) == 0)
        for (int k = 0; k < int'($urandom_range(1, 5)); k++) ring.push_back(W'($urandom));
      rdy = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 7) != 0);
      step(rdy, en, get, eget, val, mv, d, ed, last, el);
      ntests++;
      if ({get, val} !== {eget, mv}) begin
        nerr++; $display("FAIL rand_ctl: cycle %0d get,valid=%b%b want %b%b", i, get, val, eget, mv);
      end
      if (val && rdy) begin
        ntests++;
        if ({d, last} !== {ed, el}) begin
          nerr++; $display("FAIL rand_word: data %h last %b want %h %b", d, last, ed, el);
        end
      end
    end
    ntests++;
    if (overflow_error !== 1'b0) begin nerr++; $display("FAIL rand_ovf: %b want 0", overflow_error); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
    fifo_data_out = '0; fifo_data_out_valid = 1'b0; fifo_buffer_empty = 1'b1;
    clear_model();
    test_reset();
    test_stream();
    test_backpressure();
    test_empty();
    test_enable_drop();
    test_reset_mid_frame();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nerr);
    $finish;
  end

endmodule

// File: doc/ring_buffer_reader.md
RING_BUFFER_READER -- requirements
Module: ring_buffer_reader

Interface
REQ-001 Parameter WordLengthBits, 8, width of each data word.
REQ-002 Parameter FrameLengthWords, 16, words per output frame; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  permits new reads from the ring buffer.
REQ-006 fifo_get  output  1  get request to ring buffer; data arrives one cycle later.
REQ-007 fifo_data_out  input  WordLengthBits  word from ring buffer.
REQ-008 fifo_data_out_valid  input  1  fifo_data_out holds a word pulled on the last edge.
REQ-009 fifo_buffer_empty  input  1  ring buffer has no word available for this edge.
REQ-010 out_data  output  WordLengthBits  stream word.
REQ-011 out_valid  output  1  out_data/out_last valid.
REQ-012 out_ready  input  1  downstream accepts the word this edge.
REQ-013 out_last  output  1  current word is the final word of a frame.
REQ-014 overflow_error  output  1  sticky; a returned word was dropped.

Function
REQ-015 Internal holding store SHALL be a 2-entry FIFO, occupancy occ in 0..2, strict arrival order.
REQ-016 pop SHALL equal out_valid && out_ready; transfer occurs on that edge.
REQ-017 fifo_get SHALL be combinational: enable && !fifo_buffer_empty && (occ + fifo_data_out_valid - pop) <= 1.
- Path out_ready -> fifo_get is combinational by design.
REQ-018 When fifo_data_out_valid is high, fifo_data_out SHALL be written into the holding store on that edge, regardless of enable.
REQ-019 Occupancy update per edge: occ_next = occ + fifo_data_out_valid - pop.
- Simultaneous write and pop are both performed.
REQ-020 out_valid SHALL equal (occ != 0); out_data SHALL be the oldest held word.
- Both SHALL stay stable while out_valid && !out_ready.
REQ-021 Latency: a word whose get is issued at edge N SHALL appear on out_data in the cycle after edge N+1 when occ was 0.
- Sustained throughput: one word per cycle while the ring buffer is non-empty and out_ready is high.
REQ-022 Beat counter, range 0..FrameLengthWords-1, SHALL increment on each pop and wrap to 0 after FrameLengthWords-1.
REQ-023 out_last SHALL equal out_valid && (beat counter == FrameLengthWords-1).
- FrameLengthWords=1 gives out_last on every word.
REQ-024 Deasserting enable SHALL block new gets only; in-flight and held words SHALL still drain; the beat counter SHALL be kept.
REQ-025 Overflow condition: fifo_data_out_valid && occ==2 && !pop, which can only arise from an upstream protocol violation.
- The incoming word SHALL be dropped; occ stays 2.
- overflow_error SHALL set and hold until reset.
REQ-026 The block SHALL never issue fifo_get while fifo_buffer_empty is high.

Reset
REQ-027 While rst_n is low: occ=0, out_valid=0, out_last=0, beat counter=0, overflow_error=0.
- fifo_get SHALL be forced to 0.
REQ-028 Reset assertion SHALL take effect immediately, without a clock edge.
- Reset mid-frame discards held words and restarts framing at beat 0.
REQ-029 After rst_n rises, the first get SHALL be permitted on the first edge at which REQ-017 holds.

Verification
REQ-030 Stream: ring buffer preloaded with 0x01..0x20, FrameLengthWords=16, out_ready=1, enable=1.
- Expect 32 contiguous words 0x01..0x20 after 2-cycle latency.
- Expect out_last on 0x10 and 0x20.
REQ-031 Backpressure: out_ready toggled 1,0,0,1 repeatedly.
- Expect no loss, no duplication, in-order words.
- Expect occ never >2, overflow_error=0, out_data stable while stalled.
REQ-032 Empty: ring buffer holds 3 words.
- Expect exactly 3 gets and 3 words out.
- Expect fifo_get=0 while fifo_buffer_empty=1.
REQ-033 Enable drop: enable deasserted the cycle after a get.
- Expect the in-flight word still delivered and no further gets.
- Re-enable resumes with the next word; beat count continues.
REQ-034 Reset mid-frame: rst_n pulsed low at beat 5, asynchronously between edges.
- Expect out_valid=0 and fifo_get=0 immediately.
- After release, the next frame's out_last arrives on the 16th word.
REQ-035 Overflow: force fifo_data_out_valid=1 with occ=2 and out_ready=0.
- Expect the word dropped, overflow_error=1 until reset, held words unchanged.
